dma_bus_arbiter: RTL and testbench

- Sits directly upstream of the DMA engine and owns the DMA side of the system bus.
- Turns a device "block ready" indication into a one-cycle DMA command.
- Handles the BR/BG handshake so that BG is granted only between CPU memory accesses.
- Detects transfer completion from the DMA interrupt, raises a sticky CPU interrupt, counts completed blocks, and drops BG via a watchdog if the DMA stalls while holding the bus.

---
 rtl/dma_bus_arbiter.sv | 139 +++++++++++++
 tb/tb_dma_bus_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_bus_arbiter.sv
// rtl/dma_bus_arbiter.sv - DMA command issue, bus request/grant handshake and completion tracking
//
// Ports:
//   CLK          system clock, all state updates on the rising edge
//   reset_n      asynchronous active-low reset
//   dev_ready    device holds a block ready (sampled only in IDLE)
//   cpu_mem_busy CPU owns the memory bus this cycle (blocks a new grant)
//   BR           bus request from the DMA engine
//   dma_done     DMA completion level; only its rising edge completes a grant
//   irq_ack      CPU acknowledge, clears dma_irq and dma_err
//   cmd          one-cycle DMA start pulse
//   BG           bus grant to the DMA, doubles as CPU stall/tristate enable
//   dma_irq      sticky completion interrupt
//   dma_err      sticky watchdog-timeout flag
//   xfer_count   completed-transfer counter, wraps
//   busy         high whenever the FSM is not IDLE

module dma_bus_arbiter #(
  parameter int COUNT_W = 8,
  parameter int TIMEOUT = 32
) (
  input  logic               CLK,
  input  logic               reset_n,
  input  logic               dev_ready,
  input  logic               cpu_mem_busy,
  input  logic               BR,
  input  logic               dma_done,
  input  logic               irq_ack,
  output logic               cmd,
  output logic               BG,
  output logic               dma_irq,
  output logic               dma_err,
  output logic [COUNT_W-1:0] xfer_count,
  output logic               busy
);

  // TIMEOUT is limited to 255, so an 8-bit grant timer always suffices.
  localparam int         TIMER_W    = 8;
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CMD      = 3'd1,
    WAIT_BUS = 3'd2,
    GRANT    = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [TIMER_W-1:0]   timer;
  logic [TIMER_W-1:0]   timer_nxt;
  logic                 done_q;
  logic                 done_evt;
  logic                 dma_irq_nxt;
  logic                 dma_err_nxt;
  logic [COUNT_W-1:0]   xfer_count_nxt;

  // A dma_done level left over from an earlier transfer must not complete
  // the current grant, so only a fresh rising edge counts.
  assign done_evt = dma_done & ~done_q;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      timer      <= '0;
      done_q     <= 1'b0;
      dma_irq    <= 1'b0;
      dma_err    <= 1'b0;
      xfer_count <= '0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      done_q     <= dma_done;
      dma_irq    <= dma_irq_nxt;
      dma_err    <= dma_err_nxt;
      xfer_count <= xfer_count_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    timer_nxt      = '0;
    // Acknowledge clears both flags; a set in the same cycle overrides below.
    dma_irq_nxt    = dma_irq & ~irq_ack;
    dma_err_nxt    = dma_err & ~irq_ack;
    xfer_count_nxt = xfer_count;

    case (state)
      IDLE: begin
        if (dev_ready) begin
          state_nxt = CMD;
        end
      end

      CMD: begin
        state_nxt = WAIT_BUS;
      end

      WAIT_BUS: begin
        // Grant only in a gap between CPU memory accesses.
        if (BR && !cpu_mem_busy) begin
          state_nxt = GRANT;
        end
      end

      GRANT: begin
        timer_nxt = timer + 8'd1;
        // Completion takes priority over a watchdog expiry in the same cycle.
        if (done_evt) begin
          state_nxt      = RELEASE;
          timer_nxt      = '0;
          xfer_count_nxt = xfer_count + 1'b1;
          dma_irq_nxt    = 1'b1;
        end else if (timer == TIMER_LAST) begin
          state_nxt   = RELEASE;
          timer_nxt   = '0;
          dma_err_nxt = 1'b1;
        end
      end

      RELEASE: begin
        if (!BR) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Pure state decodes, so reset drops BG without waiting for a clock edge.
  assign cmd  = (state == CMD);
  assign BG   = (state == GRANT);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb/tb_dma_bus_arbiter.sv - directed-vector bench for dma_bus_arbiter

module tb_dma_bus_arbiter;

  localparam int COUNT_W = 2;
  localparam int TIMEOUT = 32;

  logic               CLK = 1'b0;
  logic               reset_n;
  logic               dev_ready;
  logic               cpu_mem_busy;
  logic               BR;
  logic               dma_done;
  logic               irq_ack;
  logic               cmd;
  logic               BG;
  logic               dma_irq;
  logic               dma_err;
  logic [COUNT_W-1:0] xfer_count;
  logic               busy;

  int vectors     = 0;
  int miscompares = 0;

  dma_bus_arbiter #(
    .COUNT_W (COUNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK          (CLK),
    .reset_n      (reset_n),
    .dev_ready    (dev_ready),
    .cpu_mem_busy (cpu_mem_busy),
    .BR           (BR),
    .dma_done     (dma_done),
    .irq_ack      (irq_ack),
    .cmd          (cmd),
    .BG           (BG),
    .dma_irq      (dma_irq),
    .dma_err      (dma_err),
    .xfer_count   (xfer_count),
    .busy         (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Advance until BG rises (bounded); reports how many cycles cmd was seen.
  task automatic wait_bg(input string tag, output int cmd_seen);
    int n;
    n        = 0;
    cmd_seen = 0;
    while (!BG && n < 10) begin
      cyc();
      n++;
      if (cmd) cmd_seen++;
    end
    check(tag, 32'(BG), 32'd1);
  endtask

  // Count cycles BG stays high, starting in the first grant cycle (bounded).
  task automatic count_bg(output int c);
    c = 0;
    while (BG && c < 64) begin
      c++;
      cyc();
    end
  endtask

  initial begin
    int c;
    int cs;
    reset_n      = 1'b0;
    dev_ready    = 1'b0;
    cpu_mem_busy = 1'b0;
    BR           = 1'b0;
    dma_done     = 1'b0;
    irq_ack      = 1'b0;
    #3;
    check("rst_cmd",   32'(cmd),        32'd0);
    check("rst_bg",    32'(BG),         32'd0);
    check("rst_irq",   32'(dma_irq),    32'd0);
    check("rst_err",   32'(dma_err),    32'd0);
    check("rst_count", 32'(xfer_count), 32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    cyc();
    reset_n = 1'b1;
    cyc();
    check("idle_busy", 32'(busy), 32'd0);

    // Basic transfer with exact latencies.
    dev_ready = 1'b1;
    cyc();
    check("t1_cmd", 32'(cmd), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    dev_ready = 1'b0;
    cyc();
    check("t1_cmd_pulse", 32'(cmd), 32'd0);
    check("t1_bg_wait", 32'(BG), 32'd0);
    cyc();
    check("t1_bg_wait2", 32'(BG), 32'd0);
    BR = 1'b1;
    cyc();
    check("t1_bg_rise", 32'(BG), 32'd1);
    c = 1;
    for (int i = 0; i < 11; i++) begin
      cyc();
      if (BG) c++;
    end
    dma_done = 1'b1;
    cyc();
    check("t1_bg_len", 32'(c), 32'd12);
    check("t1_bg_fall", 32'(BG), 32'd0);
    check("t1_irq", 32'(dma_irq), 32'd1);
    check("t1_count", 32'(xfer_count), 32'd1);
    check("t1_release_busy", 32'(busy), 32'd1);
    BR       = 1'b0;
    dma_done = 1'b0;
    cyc();
    check("t1_idle", 32'(busy), 32'd0);
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    check("t1_ack", 32'(dma_irq), 32'd0);

    // Bus contention: CPU holds the bus for 5 cycles after BR.
    dev_ready = 1'b1;
    cyc();
    dev_ready    = 1'b0;
    BR           = 1'b1;
    cpu_mem_busy = 1'b1;
    cyc();
    c = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (BG) c++;
    end
    check("t2_bg_held_off", 32'(c), 32'd0);
    cpu_mem_busy = 1'b0;
    cyc();
    check("t2_bg_rise", 32'(BG), 32'd1);
    cpu_mem_busy = 1'b1;
    cyc();
    check("t2_no_preempt", 32'(BG), 32'd1);
    dma_done = 1'b1;
    cyc();
    check("t2_bg_fall", 32'(BG), 32'd0);
    check("t2_count", 32'(xfer_count), 32'd2);
    BR           = 1'b0;
    dma_done     = 1'b0;
    cpu_mem_busy = 1'b0;
    irq_ack      = 1'b1;
    cyc();
    irq_ack = 1'b0;
    check("t2_ack", 32'(dma_irq), 32'd0);

    // Watchdog: no completion, grant lasts exactly TIMEOUT cycles.
    dev_ready = 1'b1;
    cyc();
    dev_ready = 1'b0;
    BR        = 1'b1;
    wait_bg("t3_grant", cs);
    count_bg(c);
    check("t3_bg_len", 32'(c), 32'd32);
    check("t3_err", 32'(dma_err), 32'd1);
    check("t3_irq", 32'(dma_irq), 32'd0);
    check("t3_count", 32'(xfer_count), 32'd2);
    irq_ack = 1'b1;
    BR      = 1'b0;
    cyc();
    irq_ack = 1'b0;
    check("t3_err_ack", 32'(dma_err), 32'd0);
    check("t3_idle", 32'(busy), 32'd0);

    // Stale interrupt: dma_done already high when the grant starts.
    dma_done  = 1'b1;
    dev_ready = 1'b1;
    cyc();
    dev_ready = 1'b0;
    BR        = 1'b1;
    wait_bg("t4_grant", cs);
    count_bg(c);
    check("t4_stale_len", 32'(c), 32'd32);
    check("t4_stale_err", 32'(dma_err), 32'd1);
    check("t4_stale_irq", 32'(dma_irq), 32'd0);
    check("t4_stale_count", 32'(xfer_count), 32'd2);
    irq_ack = 1'b1;
    BR      = 1'b0;
    cyc();
    irq_ack   = 1'b0;
    dev_ready = 1'b1;
    cyc();
    dev_ready = 1'b0;
    BR        = 1'b1;
    wait_bg("t4_grant2", cs);
    cyc();
    check("t4_still_granted", 32'(BG), 32'd1);
    dma_done = 1'b0;
    cyc();
    dma_done = 1'b1;
    cyc();
    check("t4_toggle_bg", 32'(BG), 32'd0);
    check("t4_toggle_irq", 32'(dma_irq), 32'd1);
    check("t4_toggle_err", 32'(dma_err), 32'd0);
    check("t4_toggle_count", 32'(xfer_count), 32'd3);
    BR       = 1'b0;
    dma_done = 1'b0;
    irq_ack  = 1'b1;
    cyc();
    irq_ack = 1'b0;

    // Completion on the same edge as the watchdog expiry: done wins.
    dev_ready = 1'b1;
    cyc();
    dev_ready = 1'b0;
    BR        = 1'b1;
    wait_bg("t5_grant", cs);
    for (int i = 0; i < 31; i++) cyc();
    check("t5_bg_last", 32'(BG), 32'd1);
    dma_done = 1'b1;
    cyc();
    check("t5_bg_fall", 32'(BG), 32'd0);
    check("t5_irq", 32'(dma_irq), 32'd1);
    check("t5_err", 32'(dma_err), 32'd0);
    check("t5_count_wrap", 32'(xfer_count), 32'd0);
    BR       = 1'b0;
    dma_done = 1'b0;
    irq_ack  = 1'b1;
    cyc();
    irq_ack = 1'b0;
    check("t5_ack", 32'(dma_irq), 32'd0);

    // irq_ack in the same cycle as the set: set wins.
    dev_ready = 1'b1;
    cyc();
    dev_ready = 1'b0;
    BR        = 1'b1;
    wait_bg("t6_grant", cs);
    cyc();
    dma_done = 1'b1;
    irq_ack  = 1'b1;
    cyc();
    irq_ack = 1'b0;
    check("t6_set_wins", 32'(dma_irq), 32'd1);
    check("t6_count", 32'(xfer_count), 32'd1);
    BR       = 1'b0;
    dma_done = 1'b0;
    cyc();
    check("t6_sticky", 32'(dma_irq), 32'd1);

    // Fresh reset, then four back-to-back blocks with dev_ready held.
    reset_n = 1'b0;
    #1;
    check("t7_rst_count", 32'(xfer_count), 32'd0);
    check("t7_rst_irq", 32'(dma_irq), 32'd0);
    cyc();
    reset_n   = 1'b1;
    dev_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      BR = 1'b1;
      wait_bg($sformatf("t7_grant%0d", i), cs);
      check($sformatf("t7_cmd_once%0d", i), 32'(cs), 32'd1);
      cyc();
      dma_done = 1'b1;
      cyc();
      check($sformatf("t7_count%0d", i), 32'(xfer_count), 32'(i % 4));
      BR       = 1'b0;
      dma_done = 1'b0;
      cyc();
    end

    // Asynchronous reset in the middle of a grant cycle.
    BR = 1'b1;
    wait_bg("t8_grant", cs);
    #2;
    reset_n = 1'b0;
    #1;
    check("t8_bg_async", 32'(BG), 32'd0);
    check("t8_cmd", 32'(cmd), 32'd0);
    check("t8_busy", 32'(busy), 32'd0);
    check("t8_irq", 32'(dma_irq), 32'd0);
    check("t8_err", 32'(dma_err), 32'd0);
    check("t8_count", 32'(xfer_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
